reu_xfer_seq: RTL
=================

REU_XFER_SEQ -- requirements
Module: reu_xfer_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed here.
REQ-002 PHI2  in  1  system clock; all state updates on negedge PHI2.
REQ-003 Reset  in  1  synchronous active-high reset.
REQ-004 ExecuteEN  in  1  command register execute bit.
REQ-005 FF00DecodeEN  in  1  1 = arm and wait for CPU write to $FF00.
REQ-006 XferType  in  2  transfer type: 00 stash C64->REU, 01 fetch REU->C64, 10 swap, 11 verify.
REQ-007 Length1  in  1  length counter equals 1.
REQ-008 FixCA, FixREUA  in  1 each  address-control bits; 1 = hold that address.
REQ-009 CPUWrFF00  in  1  CPU write strobe to $FF00 seen this cycle.
REQ-010 BA  in  1  bus available; 0 = VIC owns the bus.
REQ-011 C64DIn, RAMDIn  in  8 each  read data from C64 bus / REU RAM.
REQ-012 nDMA  out  1  DMA request to C64, active-low.
REQ-013 C64RD, C64WR, RAMRD, RAMWR  out  1 each  single-cycle bus strobes.
REQ-014 C64DOut, RAMDOut  out  8 each  write data.
REQ-015 NextCA, NextREUA  out  1 each  one-cycle address-advance pulses to the register block.
REQ-016 VerifyErr  out  1  one-cycle pulse on verify mismatch.
REQ-017 Busy  out  1  high in every state except IDLE.

Function
REQ-018 States SHALL be IDLE, ARM, SETUP, XFER, SWAPWR, DONE.
REQ-019 IDLE->ARM SHALL occur when ExecuteEN=1 and FF00DecodeEN=1; IDLE->SETUP SHALL occur when ExecuteEN=1 and FF00DecodeEN=0.
REQ-020 ARM->SETUP SHALL occur on the cycle CPUWrFF00=1.
REQ-021 SETUP SHALL assert nDMA=0 for one cycle before the first byte; nDMA SHALL stay 0 through XFER and SWAPWR, and go to 1 in DONE and IDLE.
REQ-022 Stash in XFER: C64RD=1 and RAMWR=1 in the same cycle, RAMDOut=C64DIn; 1 cycle/byte.
REQ-023 Fetch in XFER: RAMRD=1 and C64WR=1, C64DOut=RAMDIn; 1 cycle/byte.
REQ-024 Swap: XFER reads both sides into two internal latches; SWAPWR writes C64DOut=latched RAM byte and RAMDOut=latched C64 byte; 2 cycles/byte.
REQ-025 Verify: C64RD=1 and RAMRD=1; C64DIn!=RAMDIn SHALL pulse VerifyErr, issue no Next pulses, and go to DONE.
REQ-026 Each completed byte SHALL pulse NextCA and NextREUA, each gated by !FixCA / !FixREUA, in the final cycle of that byte.
REQ-027 If Length1=1 when the final cycle of a byte starts, that SHALL be the last byte, and the next state SHALL be DONE.
REQ-028 BA=0 SHALL freeze the state, with all strobes and Next pulses held at 0; the byte resumes unchanged when BA=1.
REQ-029 ExecuteEN dropping to 0 in ARM, SETUP or XFER SHALL abort: the in-flight byte's strobes are suppressed and the next state is DONE.
REQ-030 DONE SHALL last one cycle, then go to IDLE; re-arm requires ExecuteEN=1 seen again in IDLE.
REQ-031 CPUWrFF00 in any state other than ARM SHALL be ignored.
REQ-032 Strobes SHALL be registered outputs, with no combinational path from inputs to strobes.

Reset
REQ-033 Reset SHALL force state IDLE, nDMA=1, all strobes/pulses=0, Busy=0, data outputs and latches=8'h00, regardless of state, including mid-transfer.

Structure
REQ-034 A shared package SHALL hold the XferType codes (STASH, FETCH, SWAP, VERIFY) and the state encoding.
REQ-035 One sub-module, reu_swap_latch (dual 8-bit capture register with load enable), is natural; everything else is flat.

Verification
REQ-036 Stash, Length1 high on 3rd byte, C64DIn 0x11,0x22,0x33 -> RAMWR x3 with RAMDOut 0x11,0x22,0x33, 3 NextCA, DONE, nDMA=1.
REQ-037 Swap 1 byte, C64DIn=0xA5, RAMDIn=0x5A -> SWAPWR drives C64DOut=0x5A and RAMDOut=0xA5, one NextCA/NextREUA pulse.
REQ-038 Verify, 2nd byte 0x40 vs 0x41 -> VerifyErr pulse in that cycle, exactly 1 NextCA total, then IDLE.
REQ-039 FF00DecodeEN=1 -> stays ARM with nDMA=1 for 10 cycles; CPUWrFF00 pulse -> SETUP next cycle.
REQ-040 BA=0 for 3 cycles mid-fetch -> no strobes and state held; byte completes after BA=1 with data intact.
REQ-041 Reset asserted in XFER -> next cycle IDLE, nDMA=1, no strobes; FixREUA=1 run -> zero NextREUA pulses.

Source files
------------

// File: rtl/reu_xfer_seq_pkg.sv
// Shared definitions for the REU transfer sequencer.
// Holds the transfer-type codes, the sequencer state encoding and the
// bundle of single-cycle strobes that the sequencer registers each cycle.
`timescale 1ns/1ps
package reu_xfer_seq_pkg;

    typedef enum logic [1:0] {
        STASH  = 2'b00,   // C64 -> REU
        FETCH  = 2'b01,   // REU -> C64
        SWAP   = 2'b10,   // exchange, two cycles per byte
        VERIFY = 2'b11    // compare, stop on first difference
    } xfer_type_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_SETUP  = 3'd2,
        ST_XFER   = 3'd3,
        ST_SWAPWR = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    typedef struct packed {
        logic c64_rd;
        logic c64_wr;
        logic ram_rd;
        logic ram_wr;
        logic next_ca;
        logic next_reua;
        logic verify_err;
    } strobe_t;

endpackage

// File: rtl/reu_swap_latch.sv
// Dual 8-bit capture register holding both sides of a swap byte.
// Latency: captures on the falling PHI2 edge when load is high, else holds.
// Ports: clk/reset, load enable, C64 and RAM data in, captured copies out.
`timescale 1ns/1ps
module reu_swap_latch (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] c64_d,
    input  logic [7:0] ram_d,
    output logic [7:0] c64_q,
    output logic [7:0] ram_q
);

    always_ff @(negedge clk) begin
        if (reset) begin
            c64_q <= 8'h00;
            ram_q <= 8'h00;
        end else if (load) begin
            c64_q <= c64_d;
            ram_q <= ram_d;
        end
    end

endmodule

// File: rtl/reu_xfer_seq.sv
// REU DMA transfer sequencer: stash / fetch / swap / verify byte engine.
// Latency: strobes and data are registered on negedge PHI2 and appear for the
//   cycle after the edge that performed the byte; BA=0 stalls with no strobes.
// Ports: PHI2/Reset, command bits (ExecuteEN, FF00DecodeEN, XferType, Fix*),
//   Length1, CPUWrFF00, BA, read data in; nDMA, bus strobes, write data,
//   Next* address pulses, VerifyErr, Busy out.
`timescale 1ns/1ps
module reu_xfer_seq
    import reu_xfer_seq_pkg::*;
(
    input  logic       PHI2,
    input  logic       Reset,
    input  logic       ExecuteEN,
    input  logic       FF00DecodeEN,
    input  logic [1:0] XferType,
    input  logic       Length1,
    input  logic       FixCA,
    input  logic       FixREUA,
    input  logic       CPUWrFF00,
    input  logic       BA,
    input  logic [7:0] C64DIn,
    input  logic [7:0] RAMDIn,
    output logic       nDMA,
    output logic       C64RD,
    output logic       C64WR,
    output logic       RAMRD,
    output logic       RAMWR,
    output logic [7:0] C64DOut,
    output logic [7:0] RAMDOut,
    output logic       NextCA,
    output logic       NextREUA,
    output logic       VerifyErr,
    output logic       Busy
);

    state_e     state, state_nxt;
    strobe_t    strb, strb_nxt;
    logic [7:0] c64_dout, ram_dout, c64_dout_nxt, ram_dout_nxt;
    logic [7:0] lat_c64, lat_ram;
    logic       latch_load, byte_done, mismatch;
    xfer_type_e xfer;

    assign xfer     = xfer_type_e'(XferType);
    assign mismatch = (C64DIn != RAMDIn);

    reu_swap_latch u_swap_latch (
        .clk   (PHI2),
        .reset (Reset),
        .load  (latch_load),
        .c64_d (C64DIn),
        .ram_d (RAMDIn),
        .c64_q (lat_c64),
        .ram_q (lat_ram)
    );

    // State and output registers; all updates happen on the falling edge.
    always_ff @(negedge PHI2) begin
        if (Reset) begin
            state    <= ST_IDLE;
            strb     <= '0;
            c64_dout <= 8'h00;
            ram_dout <= 8'h00;
        end else begin
            state    <= state_nxt;
            strb     <= strb_nxt;
            c64_dout <= c64_dout_nxt;
            ram_dout <= ram_dout_nxt;
        end
    end

    // Next-state logic. An abort (ExecuteEN low) wins over a BA stall since
    // it produces no bus activity either way. SWAPWR cannot be aborted so a
    // half-swapped byte is always written back to both sides.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ExecuteEN) state_nxt = FF00DecodeEN ? ST_ARM : ST_SETUP;
            end
            ST_ARM: begin
                if (!ExecuteEN)     state_nxt = ST_DONE;
                else if (CPUWrFF00) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                if (!ExecuteEN) state_nxt = ST_DONE;
                else if (BA)    state_nxt = ST_XFER;
            end
            ST_XFER: begin
                if (!ExecuteEN) begin
                    state_nxt = ST_DONE;
                end else if (BA) begin
                    if (xfer == SWAP)                    state_nxt = ST_SWAPWR;
                    else if (xfer == VERIFY && mismatch) state_nxt = ST_DONE;
                    else if (Length1)                    state_nxt = ST_DONE;
                end
            end
            ST_SWAPWR: begin
                if (BA) state_nxt = Length1 ? ST_DONE : ST_XFER;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: computes what the registered strobes/data carry for the
    // cycle after this edge. Data outputs hold their last written value.
    always_comb begin
        strb_nxt     = '0;
        c64_dout_nxt = c64_dout;
        ram_dout_nxt = ram_dout;
        latch_load   = 1'b0;
        byte_done    = 1'b0;
        if (state == ST_XFER && ExecuteEN && BA) begin
            case (xfer)
                STASH: begin
                    strb_nxt.c64_rd = 1'b1;
                    strb_nxt.ram_wr = 1'b1;
                    ram_dout_nxt    = C64DIn;
                    byte_done       = 1'b1;
                end
                FETCH: begin
                    strb_nxt.ram_rd = 1'b1;
                    strb_nxt.c64_wr = 1'b1;
                    c64_dout_nxt    = RAMDIn;
                    byte_done       = 1'b1;
                end
                SWAP: begin
                    strb_nxt.c64_rd = 1'b1;
                    strb_nxt.ram_rd = 1'b1;
                    latch_load      = 1'b1;
                end
                default: begin
                    strb_nxt.c64_rd = 1'b1;
                    strb_nxt.ram_rd = 1'b1;
                    if (mismatch) strb_nxt.verify_err = 1'b1;
                    else          byte_done           = 1'b1;
                end
            endcase
        end else if (state == ST_SWAPWR && BA) begin
            strb_nxt.c64_wr = 1'b1;
            strb_nxt.ram_wr = 1'b1;
            c64_dout_nxt    = lat_ram;
            ram_dout_nxt    = lat_c64;
            byte_done       = 1'b1;
        end
        strb_nxt.next_ca   = byte_done && !FixCA;
        strb_nxt.next_reua = byte_done && !FixREUA;
    end

    assign C64RD     = strb.c64_rd;
    assign C64WR     = strb.c64_wr;
    assign RAMRD     = strb.ram_rd;
    assign RAMWR     = strb.ram_wr;
    assign NextCA    = strb.next_ca;
    assign NextREUA  = strb.next_reua;
    assign VerifyErr = strb.verify_err;
    assign C64DOut   = c64_dout;
    assign RAMDOut   = ram_dout;
    assign nDMA      = !(state == ST_SETUP || state == ST_XFER || state == ST_SWAPWR);
    assign Busy      = (state != ST_IDLE);

endmodule
